// File: rtl/starflux_pkg.sv
// Shared types and defaults for the starflux game datapath.
// Timer width is shared with the rate dividers.
package starflux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RECOVER,
    LOCKOUT
  } state_e;

  localparam int TIMER_W         = 28;
  localparam int FIRE_GAP_DEF    = 50_000_000;
  localparam int COOL_PERIOD_DEF = 100_000_000;

endpackage

// File: rtl/heat_cool_timer.sv
// Free-running down-counter; emits a 1-cycle tick every COOL_PERIOD cycles.
module heat_cool_timer
  import starflux_pkg::*;
#(
  parameter int COOL_PERIOD = COOL_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(COOL_PERIOD - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? RELOAD : cnt_q - TIMER_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gun_fire_scheduler.sv
// Round-robin fire arbiter with shot spacing, heat tracking and
// overheat lockout driving the shared bullet-spawn path.
module gun_fire_scheduler
  import starflux_pkg::*;
#(
  parameter int FIRE_GAP      = FIRE_GAP_DEF,
  parameter int COOL_PERIOD   = COOL_PERIOD_DEF,
  parameter int HEAT_W        = 4,
  parameter int HEAT_MAX      = 15,
  parameter int HEAT_RESUME   = 4,
  parameter int HEAT_PER_SHOT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        fire_req,
  output logic              bullet_valid,
  input  logic              bullet_ready,
  output logic              bullet_owner,
  output logic [HEAT_W-1:0] heat,
  output logic              overheated
);

  localparam logic [TIMER_W-1:0] GAP_RELOAD = TIMER_W'(FIRE_GAP - 1);
  localparam logic [HEAT_W-1:0]  H_MAX = HEAT_W'(HEAT_MAX);
  localparam logic [HEAT_W-1:0]  H_RES = HEAT_W'(HEAT_RESUME);
  localparam logic [HEAT_W-1:0]  H_INC = HEAT_W'(HEAT_PER_SHOT);

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               ovh_q, ovh_d;
  logic [HEAT_W-1:0]  heat_q, heat_d;
  logic [TIMER_W-1:0] gap_q, gap_d;

  logic              tick;
  logic              grant;
  logic [HEAT_W:0]   heat_sum;
  logic [HEAT_W-1:0] heat_shot;

  heat_cool_timer #(
    .COOL_PERIOD(COOL_PERIOD)
  ) u_cool (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (fire_req == 2'b10): grant = 1'b1;
      (fire_req == 2'b11): grant = ~last_q;
      default:             grant = 1'b0;
    endcase
  end

  always_comb begin
    heat_sum  = {1'b0, heat_q} + {1'b0, H_INC};
    heat_shot = (heat_sum >= {1'b0, H_MAX}) ? H_MAX
                                            : heat_sum[HEAT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    heat_d  = heat_q;
    gap_d   = gap_q;
    // ISSUE is excluded so a tick can never collide with a shot charge
    if (tick && heat_q != '0 && state_q != ISSUE)
      heat_d = heat_q - HEAT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (heat_q >= H_MAX) begin
          state_d = LOCKOUT;
        end else if (fire_req != 2'b00) begin
          owner_d = grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bullet_ready) begin
          heat_d  = heat_shot;
          last_d  = owner_q;
          gap_d   = GAP_RELOAD;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (gap_q == '0)
          state_d = (heat_q >= H_MAX) ? LOCKOUT : IDLE;
        else
          gap_d = gap_q - TIMER_W'(1);
      end
      LOCKOUT: begin
        if (heat_q <= H_RES) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == ISSUE);
    ovh_d   = (state_d == LOCKOUT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ovh_q   <= 1'b0;
      heat_q  <= '0;
      gap_q   <= GAP_RELOAD;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ovh_q   <= ovh_d;
      heat_q  <= heat_d;
      gap_q   <= gap_d;
    end
  end

  assign bullet_valid = valid_q;
  assign bullet_owner = owner_q;
  assign heat         = heat_q;
  assign overheated   = ovh_q;

endmodule

// File: tb/tb_gun_fire_scheduler.sv
// Directed bench for gun_fire_scheduler with a shot scoreboard.
module tb_gun_fire_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] fire_req = 2'b00;
  logic       bullet_ready = 1'b1;
  logic       bullet_valid, bullet_owner, overheated;
  logic [3:0] heat;

  logic [1:0] fire_req2 = 2'b00;
  logic       ready2 = 1'b1;
  logic       valid2, owner2, ovh2;
  logic [3:0] heat2;

  typedef struct {
    int   cyc;
    logic own;
    int   heat;
  } shot_t;

  shot_t sb[$];
  int    r;
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clock = ~clock;

  gun_fire_scheduler #(
    .FIRE_GAP(3), .COOL_PERIOD(8), .HEAT_W(4),
    .HEAT_MAX(3), .HEAT_RESUME(1), .HEAT_PER_SHOT(1)
  ) dut (
    .clock(clock), .reset(reset), .fire_req(fire_req),
    .bullet_valid(bullet_valid), .bullet_ready(bullet_ready),
    .bullet_owner(bullet_owner), .heat(heat),
    .overheated(overheated)
  );

  gun_fire_scheduler #(
    .FIRE_GAP(3), .COOL_PERIOD(8), .HEAT_W(4),
    .HEAT_MAX(3), .HEAT_RESUME(1), .HEAT_PER_SHOT(2)
  ) dut2 (
    .clock(clock), .reset(reset), .fire_req(fire_req2),
    .bullet_valid(valid2), .bullet_ready(ready2),
    .bullet_owner(owner2), .heat(heat2),
    .overheated(ovh2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    r++;
  endtask

  task automatic step_to(input int t);
    while (r < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    r = 0;
  endtask

  task automatic run_shot(input int budget);
    shot_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    while (bullet_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("shot_valid", bullet_valid, 1);
    check("shot_cycle", r, e.cyc);
    check("shot_owner", bullet_owner, e.own);
    step();
    check("shot_heat", heat, e.heat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", bullet_valid, 0);
    check("rst_owner", bullet_owner, 0);
    check("rst_heat", heat, 0);
    check("rst_ovh", overheated, 0);

    // single requester
    do_reset();
    step();
    fire_req = 2'b01;
    sb.push_back('{2, 1'b0, 1});
    sb.push_back('{7, 1'b0, 2});
    sb.push_back('{12, 1'b0, 3});
    run_shot(10);
    run_shot(10);
    run_shot(10);
    step_to(15);
    check("a_ovh_pre", overheated, 0);
    step_to(16);
    check("a_ovh", overheated, 1);
    check("a_lock_valid", bullet_valid, 0);
    check("a_lock_heat", heat, 2);
    step_to(24);
    check("a_cool_heat", heat, 1);
    check("a_ovh_hold", overheated, 1);
    step_to(25);
    check("a_ovh_fall", overheated, 0);
    fire_req = 2'b00;

    // contention
    do_reset();
    step();
    fire_req = 2'b11;
    sb.push_back('{2, 1'b0, 1});
    sb.push_back('{7, 1'b1, 2});
    sb.push_back('{12, 1'b0, 3});
    sb.push_back('{26, 1'b1, 2});
    run_shot(10);
    run_shot(10);
    run_shot(10);
    step_to(16);
    check("b_ovh", overheated, 1);
    run_shot(20);
    fire_req = 2'b00;

    // backpressure
    bullet_ready = 1'b0;
    do_reset();
    step();
    fire_req = 2'b01;
    step();
    fire_req = 2'b00;
    for (int i = 0; i < 10; i++) begin
      check("c_valid", bullet_valid, 1);
      check("c_owner", bullet_owner, 0);
      check("c_heat", heat, 0);
      if (i < 9) step();
    end
    bullet_ready = 1'b1;
    step();
    check("c_valid_drop", bullet_valid, 0);
    check("c_heat_shot", heat, 1);

    // saturation with 2 heat per shot
    do_reset();
    step();
    fire_req2 = 2'b01;
    step();
    check("d_valid1", valid2, 1);
    step();
    check("d_heat1", heat2, 2);
    step_to(7);
    check("d_valid2", valid2, 1);
    step();
    check("d_heat_sat", heat2, 3);
    step_to(10);
    check("d_ovh_pre", ovh2, 0);
    step();
    check("d_ovh", ovh2, 1);
    check("d_lock_valid", valid2, 0);
    fire_req2 = 2'b00;

    // cooling
    do_reset();
    step();
    fire_req = 2'b01;
    sb.push_back('{2, 1'b0, 1});
    sb.push_back('{7, 1'b0, 2});
    run_shot(10);
    run_shot(10);
    fire_req = 2'b00;
    step_to(15);
    check("e_heat_pre", heat, 2);
    step_to(16);
    check("e_heat_t1", heat, 1);
    step_to(24);
    check("e_heat_t2", heat, 0);
    step_to(32);
    check("e_heat_floor", heat, 0);
    check("e_idle_valid", bullet_valid, 0);

    // async reset while a bullet is pending
    do_reset();
    step();
    fire_req = 2'b11;
    sb.push_back('{2, 1'b0, 1});
    run_shot(10);
    bullet_ready = 1'b0;
    step_to(7);
    check("f_valid_pend", bullet_valid, 1);
    check("f_owner_pend", bullet_owner, 1);
    check("f_heat_pend", heat, 1);
    #3;
    reset = 1'b1;
    #1;
    check("f_async_valid", bullet_valid, 0);
    check("f_async_heat", heat, 0);
    check("f_async_ovh", overheated, 0);
    #1;
    reset = 1'b0;
    bullet_ready = 1'b1;
    r = 0;
    sb.push_back('{1, 1'b0, 1});
    run_shot(10);
    fire_req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gun_fire_scheduler.md
# gun_fire_scheduler

Sequences shots from two fire requesters (player 1 and player 2) onto the single shared gun and bullet-spawn path. It arbitrates the requesters round-robin and spaces shots by a minimum gap. It tracks gun heat, cooling it on a periodic tick, and enforces an overheat lockout with hysteresis. It sits between the switch/key input logic and the bullet engine, and its heat output drives the heat bar display.

## Interface
- `FIRE_GAP`, 50_000_000: cycles spent in RECOVER after each accepted shot; ≥1 (1 s at 50 MHz).
- `COOL_PERIOD`, 100_000_000: cycles between cooling ticks; ≥2 (2 s at 50 MHz).
- `HEAT_W`, 4: heat width.
- `HEAT_MAX`, 15: saturation and lockout level; ≤ 2^HEAT_W−1.
- `HEAT_RESUME`, 4: lockout exits when heat ≤ this; < HEAT_MAX.
- `HEAT_PER_SHOT`, 1: heat added per accepted shot; ≥1.
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `fire_req`  in  2  level requests; bit0 = player 1, bit1 = player 2.
- `bullet_valid`  out  1  spawn request to bullet engine.
- `bullet_ready`  in  1  bullet engine has a free slot; handshake when valid & ready.
- `bullet_owner`  out  1  requester id of the pending/last shot.
- `heat`  out  HEAT_W  current heat.
- `overheated`  out  1  high while in LOCKOUT.

## Operation
- Reset values: state IDLE, `bullet_valid`=0, `bullet_owner`=0, `heat`=0, `overheated`=0, last_grant=1, gap and cool counters reloaded.
- States:
  - IDLE:
    - If heat ≥ HEAT_MAX → LOCKOUT. This check has priority.
    - Otherwise, if `fire_req`≠0, arbitrate, latch owner → ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: `bullet_valid`=1. Owner is held stable. On handshake: heat ← min(heat+HEAT_PER_SHOT, HEAT_MAX), last_grant ← owner, gap counter ← FIRE_GAP−1 → RECOVER.
  - RECOVER: counts the gap counter down. At 0 → LOCKOUT if heat ≥ HEAT_MAX, else IDLE.
  - LOCKOUT: `overheated`=1 and requests are ignored. → IDLE when heat ≤ HEAT_RESUME.
- Arbitration:
  - A single requester wins.
  - If both request, grant the requester ≠ last_grant. After reset, player 1 wins the first contention.
  - last_grant updates only on handshake.
- No retraction: once `bullet_valid` rises it stays high until handshake, even if `fire_req` drops. `bullet_owner` is unchanged throughout.
- Cooling:
  - Free-running cool counter: a tick fires every COOL_PERIOD cycles, independent of state.
  - The tick decrements heat by 1 if heat>0 and state≠ISSUE. Ticks during ISSUE are discarded, so shot and tick never collide.
  - heat never wraps: saturates at HEAT_MAX and floors at 0.
- Reset mid-operation: a pending bullet is dropped. `bullet_valid` falls asynchronously and no heat is charged.

## Timing
- All outputs are registered. `bullet_valid` asserts 1 cycle after `fire_req` is sampled in IDLE.
- Heat updates on the edge ending the handshake cycle.
- With `bullet_ready` tied high:
  - ISSUE lasts 1 cycle, RECOVER lasts FIRE_GAP cycles, IDLE lasts 1 cycle.
  - Shot-to-shot period is FIRE_GAP+2 cycles.
- `overheated` rises the cycle after RECOVER ends with heat=HEAT_MAX. It falls the cycle after heat reaches HEAT_RESUME.
- Cooling-tick heat change is visible 1 cycle after the tick.

## Structure
- Shared package `starflux_pkg`:
  - state enum (IDLE, ISSUE, RECOVER, LOCKOUT);
  - default FIRE_GAP/COOL_PERIOD constants;
  - 28-bit timer width constant, shared with the rate dividers.
- One sub-module, `heat_cool_timer`: a parameterised down-counter with asynchronous reset that emits a 1-cycle `tick` every COOL_PERIOD cycles.
- Arbiter, FSM, gap counter and heat register live in the top module.

## Test plan
Overrides for all scenarios: FIRE_GAP=3, COOL_PERIOD=8, HEAT_MAX=3, HEAT_RESUME=1, HEAT_PER_SHOT=1; the first cooling tick is at cycle 8.
- **Single requester:** `fire_req`=01 from cycle 0, `bullet_ready`=1.
  - `bullet_valid` pulses at cycles 1, 6, 11; owner 0 each time.
  - heat after each shot: 1, 2, 3 (the tick at cycle 8 does not cool, it only offsets the cycle-16 tick).
  - Then `overheated`=1 from cycle 15, `bullet_valid` stays low.
- **Contention:** `fire_req`=11, ready high → owners 0,1,0. Lockout holds until two cooling ticks bring heat 3→1; the next shot goes to owner 1.
- **Backpressure:** valid raised, `bullet_ready`=0 for 10 cycles, `fire_req` dropped at cycle 2.
  - valid stays high, owner stable, heat unchanged.
  - Ready pulse → heat+1, then RECOVER.
- **Saturation:** HEAT_PER_SHOT=2 override, two shots → heat 2 then 3 (not 4); LOCKOUT after the second RECOVER.
- **Cooling:** heat=2, idle, no requests → heat 1 after the next tick, 0 after the following tick, stays 0; a tick during ISSUE leaves heat unchanged.
- **Async reset in ISSUE:** pulse `reset` mid-cycle.
  - `bullet_valid`, heat and `overheated` go to 0 before the next edge.
  - After release, `fire_req`=11 → first grant is owner 0.
